// File: rtl/bind_assert_arbiter.sv
// Coalesces bound-checker fail pulses into saturating counters and round-robin reports them.
// Optional report timeout/drop enabled by BIND_ASSERT_ARB_TIMEOUT_EN.
module bind_assert_arbiter #(
    parameter int N_MON   = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic [N_MON-1:0] fail,
    input  logic             enable,
    input  logic             clear,
    output logic             report_valid,
    input  logic             report_ready,
    output logic [ID_W-1:0]  report_id,
    output logic [CNT_W-1:0] report_count,
    output logic             overflow,
    output logic             any_fail,
    output logic             stall
);

    typedef enum logic {IDLE, REPORT} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q [N_MON];
    logic [CNT_W-1:0] cnt_d [N_MON];
    logic [ID_W-1:0]  rr_q;
    logic [ID_W-1:0]  rr_next;
    logic [ID_W-1:0]  grant;
    logic [ID_W:0]    idx;
    logic             found;
    logic             grab;
    logic             sat_hit;
    logic             valid_q;
    logic [ID_W-1:0]  id_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic             any_fail_q;
    logic [N_MON-1:0] cap;
    logic             drop;

    assign cap = fail & {N_MON{enable}};

    // First nonzero counter at or after rr, wrapping.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_MON; k++) begin
            idx = {1'b0, rr_q} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(N_MON))
                idx = idx - (ID_W+1)'(N_MON);
            if (!found && cnt_q[idx[ID_W-1:0]] != '0) begin
                found = 1'b1;
                grant = idx[ID_W-1:0];
            end
        end
    end

    assign grab = (state_q == IDLE) && found;

    always_comb begin
        sat_hit = 1'b0;
        for (int i = 0; i < N_MON; i++) begin
            cnt_d[i] = cnt_q[i];
            if (grab && grant == ID_W'(i))
                cnt_d[i] = '0;
            if (cap[i]) begin
                if (&cnt_d[i])
                    sat_hit = 1'b1;
                else
                    cnt_d[i] = cnt_d[i] + 1'b1;
            end
        end
    end

    assign rr_next = (id_q == ID_W'(N_MON-1)) ? '0 : id_q + 1'b1;

`ifdef BIND_ASSERT_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] stall_cnt_q;
    logic            stall_q;

    assign drop  = (state_q == REPORT) && !report_ready &&
                   (stall_cnt_q == TO_W'(TIMEOUT - 1));
    assign stall = stall_q;

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
        end else if (clear) begin
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
        end else begin
            stall_q <= drop;
            if (state_q == REPORT && !report_ready && !drop)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            else
                stall_cnt_q <= '0;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT;
    assign drop           = 1'b0;
    assign stall          = 1'b0;
`endif

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            for (int i = 0; i < N_MON; i++)
                cnt_q[i] <= '0;
            state_q    <= IDLE;
            rr_q       <= '0;
            valid_q    <= 1'b0;
            id_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            any_fail_q <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < N_MON; i++)
                cnt_q[i] <= '0;
            state_q    <= IDLE;
            rr_q       <= '0;
            valid_q    <= 1'b0;
            id_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            any_fail_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            overflow_q <= overflow_q | sat_hit | drop;
            any_fail_q <= any_fail_q | (|cap);
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        id_q    <= grant;
                        count_q <= cnt_q[grant];
                        valid_q <= 1'b1;
                        state_q <= REPORT;
                    end
                end
                REPORT: begin
                    if (report_ready || drop) begin
                        valid_q <= 1'b0;
                        rr_q    <= rr_next;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign report_valid = valid_q;
    assign report_id    = id_q;
    assign report_count = count_q;
    assign overflow     = overflow_q;
    assign any_fail     = any_fail_q;

endmodule

// File: tb/tb_bind_assert_arbiter.sv
// Directed bench for bind_assert_arbiter with hand-computed expectations.
// Timeout branch checked when BIND_ASSERT_ARB_TIMEOUT_EN is defined.
module tb_bind_assert_arbiter;

    logic       CLK = 1'b0;
    logic       ASYNCRESETN;
    logic [3:0] fail;
    logic       enable;
    logic       clear;
    logic       report_valid;
    logic       report_ready;
    logic [1:0] report_id;
    logic [7:0] report_count;
    logic       overflow;
    logic       any_fail;
    logic       stall;

    int n_checks = 0;
    int n_fail   = 0;

    bind_assert_arbiter #(
        .N_MON(4), .ID_W(2), .CNT_W(8), .TIMEOUT(16)
    ) dut (
        .CLK         (CLK),
        .ASYNCRESETN (ASYNCRESETN),
        .fail        (fail),
        .enable      (enable),
        .clear       (clear),
        .report_valid(report_valid),
        .report_ready(report_ready),
        .report_id   (report_id),
        .report_count(report_count),
        .overflow    (overflow),
        .any_fail    (any_fail),
        .stall       (stall)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        int bad;
        ASYNCRESETN  = 1'b0;
        fail         = '0;
        enable       = 1'b1;
        clear        = 1'b0;
        report_ready = 1'b0;
        #12;
        check("rst_valid", report_valid, 0);
        check("rst_id", report_id, 0);
        check("rst_count", report_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_any", any_fail, 0);
        check("rst_stall", stall, 0);
        ASYNCRESETN = 1'b1;
        step();

        // single fail[2]
        report_ready = 1'b1;
        fail = 4'b0100;
        step();
        fail = '0;
        check("t1_lat0", report_valid, 0);
        step();
        check("t1_valid", report_valid, 1);
        check("t1_id", report_id, 2);
        check("t1_count", report_count, 1);
        check("t1_any", any_fail, 1);
        step();
        check("t1_done", report_valid, 0);

        // coalescing while stalled
        do_clear();
        report_ready = 1'b0;
        fail = 4'b0010;
        for (int i = 0; i < 5; i++) step();
        fail = '0;
        check("t2_valid", report_valid, 1);
        check("t2_id", report_id, 1);
        check("t2_count1", report_count, 1);
        report_ready = 1'b1;
        step();
        check("t2_hs", report_valid, 0);
        step();
        check("t2_v2", report_valid, 1);
        check("t2_id2", report_id, 1);
        check("t2_count4", report_count, 4);
        step();

        // round robin order
        do_clear();
        fail = 4'b1111;
        step();
        fail = '0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t3_valid", report_valid, 1);
            check("t3_id", report_id, k);
            check("t3_cnt", report_count, 1);
            step();
            check("t3_hs", report_valid, 0);
        end
        fail = 4'b1001;
        step();
        fail = '0;
        step();
        check("t3_wrap_id0", report_id, 0);
        step();
        step();
        check("t3_wrap_id3", report_id, 3);
        check("t3_wrap_v", report_valid, 1);
        step();

        // enable low ignores fail
        enable = 1'b0;
        fail = 4'b0100;
        step();
        fail = '0;
        enable = 1'b1;
        step();
        step();
        check("en_off", report_valid, 0);

        // saturation
        do_clear();
        report_ready = 1'b0;
        fail = 4'b0001;
        for (int i = 0; i < 300; i++) step();
        fail = '0;
        check("t4_first", report_count, 1);
        check("t4_ovf", overflow, 1);
        report_ready = 1'b1;
        step();
        step();
        check("t4_id", report_id, 0);
        check("t4_sat", report_count, 255);
        step();
        check("t4_ovf_sticky", overflow, 1);

        // clear during report
        report_ready = 1'b0;
        fail = 4'b0100;
        step();
        fail = 4'b0001;
        step();
        fail = '0;
        check("t5_pre_v", report_valid, 1);
        do_clear();
        check("t5_v", report_valid, 0);
        check("t5_ovf", overflow, 0);
        check("t5_any", any_fail, 0);
        step();
        step();
        check("t5_cnt0", report_valid, 0);

        // async reset mid-report
        fail = 4'b0100;
        step();
        fail = '0;
        step();
        check("t5_rv", report_valid, 1);
        #3 ASYNCRESETN = 1'b0;
        #1;
        check("ar_valid", report_valid, 0);
        check("ar_id", report_id, 0);
        check("ar_count", report_count, 0);
        check("ar_any", any_fail, 0);
        #2 ASYNCRESETN = 1'b1;
        step();

        // long stall
        report_ready = 1'b0;
        fail = 4'b1000;
        step();
        fail = '0;
        step();
        check("t6_v", report_valid, 1);
`ifdef BIND_ASSERT_ARB_TIMEOUT_EN
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (report_valid !== 1'b1 || stall !== 1'b0) bad++;
        end
        check("t6_pre", bad, 0);
        step();
        check("t6_stall", stall, 1);
        check("t6_drop", report_valid, 0);
        check("t6_ovf", overflow, 1);
        step();
        check("t6_pulse", stall, 0);
        check("t6_idle", report_valid, 0);
`else
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (report_valid !== 1'b1 || stall !== 1'b0) bad++;
        end
        check("t6_hold", bad, 0);
        check("t6_id", report_id, 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
